// File: rtl/decode_issue_stage_pkg.sv
// Shared decode definitions for the ID->EX stage: RV32 opcodes, immediate formats
// and the per-opcode usage table.
package decode_issue_stage_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    FMT_NONE,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } imm_fmt_e;

  typedef struct packed {
    logic rs1_used;
    logic rs2_used;
    logic writes_rd;
    logic is_load;
  } usage_t;

  function automatic imm_fmt_e imm_fmt_of(input logic [6:0] opcode);
    case (opcode)
      OP_IMM, OP_LOAD, OP_JALR: return FMT_I;
      OP_STORE:                 return FMT_S;
      OP_BRANCH:                return FMT_B;
      OP_LUI, OP_AUIPC:         return FMT_U;
      OP_JAL:                   return FMT_J;
      default:                  return FMT_NONE;
    endcase
  endfunction

  // Unknown opcodes fall to all-zero usage: they issue but never write or forward.
  function automatic usage_t usage_of(input logic [6:0] opcode);
    usage_t u;
    u = '0;
    case (opcode)
      OP_R:      begin u.rs1_used = 1'b1; u.rs2_used = 1'b1; u.writes_rd = 1'b1; end
      OP_IMM:    begin u.rs1_used = 1'b1; u.writes_rd = 1'b1; end
      OP_LOAD:   begin u.rs1_used = 1'b1; u.writes_rd = 1'b1; u.is_load = 1'b1; end
      OP_STORE:  begin u.rs1_used = 1'b1; u.rs2_used = 1'b1; end
      OP_BRANCH: begin u.rs1_used = 1'b1; u.rs2_used = 1'b1; end
      OP_JALR:   begin u.rs1_used = 1'b1; u.writes_rd = 1'b1; end
      OP_JAL, OP_LUI, OP_AUIPC: u.writes_rd = 1'b1;
      default:   u = '0;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/decode_issue_stage_imm_gen.sv
// Combinational immediate generator: picks the I/S/B/U/J layout from the opcode and
// sign-extends the result to XLEN.
module imm_gen
  import decode_issue_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm
);

  imm_fmt_e    fmt;
  logic [31:0] imm32;

  assign fmt = imm_fmt_of(instr[6:0]);

  always_comb begin
    imm32 = '0;
    case (fmt)
      FMT_I: imm32 = {{20{instr[31]}}, instr[31:20]};
      FMT_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U: imm32 = {instr[31:12], 12'b0};
      FMT_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_issue_stage.sv
// ID->EX stage: decode, register read with WB bypass, load-use bubble insertion and
// branch flush, registering the stage1 bundle consumed by forwarding and the ALU.
module decode_issue_stage
  import decode_issue_stage_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   if_valid,
  input  logic [XLEN-1:0]        if_pc,
  input  logic [31:0]            if_instr,
  output logic [4:0]             rf_rs1_addr,
  output logic [4:0]             rf_rs2_addr,
  input  logic [XLEN-1:0]        rf_rs1_data,
  input  logic [XLEN-1:0]        rf_rs2_data,
  input  logic [4:0]             wb_dest,
  input  logic                   wb_we,
  input  logic [XLEN-1:0]        wb_data,
  input  logic                   flush,
  output logic                   stall_fetch,
  output logic                   valid_stage1,
  output logic [XLEN-1:0]        PC_stage1,
  output logic [31:0]            instr_stage1,
  output logic [4:0]             rs1_stage1,
  output logic [4:0]             rs2_stage1,
  output logic [4:0]             rd_stage1,
  output logic                   write_reg_stage1,
  output logic                   mem_read_stage1,
  output logic [XLEN-1:0]        operand1_stage1,
  output logic [XLEN-1:0]        operand2_stage1,
  output logic [XLEN-1:0]        imm_stage1,
  output logic [STALL_CNT_W-1:0] stall_count
);

  usage_t          use_d;
  logic [4:0]      rs1_d;
  logic [4:0]      rs2_d;
  logic [4:0]      rd_d;
  logic [XLEN-1:0] op1_d;
  logic [XLEN-1:0] op2_d;
  logic [XLEN-1:0] imm_d;
  logic            rs1_hit;
  logic            rs2_hit;
  logic            use_hazard;
  logic            issue;

  function automatic logic [XLEN-1:0] read_operand(input logic [4:0]      addr,
                                                   input logic [XLEN-1:0] rf_data);
    if (addr == 5'd0)                       return '0;
    else if (wb_we && wb_dest == addr)      return wb_data;
    else                                    return rf_data;
  endfunction

  assign rf_rs1_addr = if_instr[19:15];
  assign rf_rs2_addr = if_instr[24:20];

  assign use_d = usage_of(if_instr[6:0]);
  assign rs1_d = use_d.rs1_used ? if_instr[19:15] : 5'd0;
  assign rs2_d = use_d.rs2_used ? if_instr[24:20] : 5'd0;
  assign rd_d  = if_instr[11:7];
  assign op1_d = read_operand(rs1_d, rf_rs1_data);
  assign op2_d = read_operand(rs2_d, rf_rs2_data);

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (if_instr),
    .imm   (imm_d)
  );

  // Back-pressure contract: stall_fetch=1 means IF/ID must hold PC and instruction and
  // re-present the same word next cycle; the stage consumes IF/ID exactly on cycles where
  // if_valid=1 and stall_fetch=0 and flush=0. Flush always wins over a stall.
  assign rs1_hit    = use_d.rs1_used && rs1_d == rd_stage1;
  assign rs2_hit    = use_d.rs2_used && rs2_d == rd_stage1;
  assign use_hazard = if_valid && valid_stage1 && mem_read_stage1 &&
                      rd_stage1 != 5'd0 && (rs1_hit || rs2_hit);
  assign stall_fetch = use_hazard && !flush;
  assign issue       = if_valid && !flush && !use_hazard;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_stage1     <= 1'b0;
      PC_stage1        <= '0;
      instr_stage1     <= '0;
      rs1_stage1       <= '0;
      rs2_stage1       <= '0;
      rd_stage1        <= '0;
      write_reg_stage1 <= 1'b0;
      mem_read_stage1  <= 1'b0;
      operand1_stage1  <= '0;
      operand2_stage1  <= '0;
      imm_stage1       <= '0;
    end else if (!issue) begin
      valid_stage1     <= 1'b0;
      PC_stage1        <= '0;
      instr_stage1     <= '0;
      rs1_stage1       <= '0;
      rs2_stage1       <= '0;
      rd_stage1        <= '0;
      write_reg_stage1 <= 1'b0;
      mem_read_stage1  <= 1'b0;
      operand1_stage1  <= '0;
      operand2_stage1  <= '0;
      imm_stage1       <= '0;
    end else begin
      valid_stage1     <= 1'b1;
      PC_stage1        <= if_pc;
      instr_stage1     <= if_instr;
      rs1_stage1       <= rs1_d;
      rs2_stage1       <= rs2_d;
      rd_stage1        <= rd_d;
      write_reg_stage1 <= use_d.writes_rd && rd_d != 5'd0;
      mem_read_stage1  <= use_d.is_load;
      operand1_stage1  <= op1_d;
      operand2_stage1  <= op2_d;
      imm_stage1       <= imm_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_count <= '0;
    else if (stall_fetch && stall_count != {STALL_CNT_W{1'b1}})
      stall_count <= stall_count + 1'b1;
  end

endmodule
